icache_refill_bridge: RTL and testbench
=======================================

// Module: icache_refill_bridge
// PURPOSE
//  Memory-side responder for icache line-refill requests. Takes one line-read request
//  (request/addr handshake), issues a single AXI4 INCR burst read, and packs the returned
//  32-bit beats into a 256-bit line. Returns the line to the icache with a one-cycle
//  mem_return_en pulse. Sits between the icache and the AXI interconnect.
// PARAMETERS
//  ADDR_W      32    address width
//  LINE_W      256   cache-line width in bits
//  AXI_DW      32    AXI data width; BEATS = LINE_W/AXI_DW = 8
//  ID_W        4     AXI ID width
//  AXI_ID      0     fixed ARID value for all refills
// PORTS
//  clk                     in   1        clock
//  rst_n                   in   1        asynchronous reset, active-low
//  icache_mem_read_request in   1        icache refill request, held until mem_read_addr_ok
//  icache_mem_read_addr    in   ADDR_W   refill address (any byte inside the line)
//  mem_ready_to_read       out  1        bridge idle, can accept a request
//  mem_read_addr_ok        out  1        one-cycle pulse, request accepted
//  mem_return_en           out  1        one-cycle pulse, mem_return_data valid
//  mem_return_data         out  LINE_W   assembled line; word i = bits [32i+31:32i]
//  mem_return_err          out  1        valid with mem_return_en: SLVERR/DECERR or bad burst length
//  arid/araddr             out  ID_W/ADDR_W  AXI AR channel
//  arlen/arsize/arburst    out  8/3/2    fixed: BEATS-1, 3'b010, 2'b01 (INCR)
//  arvalid                 out  1        AR valid
//  arready                 in   1        AR ready
//  rid/rdata/rresp         in   ID_W/AXI_DW/2  AXI R channel; rid is not checked
//  rlast/rvalid            in   1/1      R channel last / valid
//  rready                  out  1        R ready
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; beat_cnt=0; line buffer=0; err=0; every output 0
//    except mem_ready_to_read=1. Reset mid-burst aborts to IDLE with no mem_return_en.
//  - FSM states IDLE -> AR -> R -> RESP -> IDLE.
//  - IDLE: mem_ready_to_read=1. On request=1 at a clock edge: latch
//    addr & ~(LINE_W/8-1) (low 5 bits cleared), clear buffer/err/beat_cnt, go to AR.
//  - AR: mem_read_addr_ok=1 in the first AR cycle only. arvalid=1 with araddr=aligned addr.
//    arvalid and all AR fields stay stable until arready. On arvalid&&arready go to R.
//  - R: rready=1. Each rvalid beat writes rdata to word beat_cnt, then beat_cnt++
//    (3-bit counter). rresp!=2'b00 on any beat sets err (sticky).
//    Leave R when the beat has rlast=1 or beat_cnt==BEATS-1.
//    rlast before beat 7: err=1, unfilled words stay 0.
//    Beat 7 without rlast: err=1, go to RESP anyway.
//  - RESP: mem_return_en=1 and mem_return_err=err for exactly one cycle, then IDLE.
//    mem_return_data holds the buffer from RESP until the next request is accepted.
//  - A request seen during AR/R/RESP is ignored; the icache must keep it asserted.
//    A request still high in the IDLE cycle after RESP is a new request.
//  - Latency with arready=1 and rvalid every cycle: request sampled at edge 0,
//    addr_ok and AR handshake in cycle 1, beats in cycles 2-9, mem_return_en in cycle 10.
//    Idle-to-idle occupancy is 11 cycles, minimum 1 IDLE cycle between refills.
//  - Only one outstanding transaction. No write channel.
// TESTING
//  1. Reset mid-burst: rst_n low during R -> all outputs 0, mem_ready_to_read=1 after
//     release, no mem_return_en.
//  2. Basic refill: addr=0x1C00_0014, arready=1, rdata=0xA0+i every cycle with rlast on beat 7
//     -> araddr=0x1C00_0000, arlen=7, mem_return_en in cycle 10,
//     data word i=0xA0+i, err=0.
//  3. Backpressure: arready low for 3 cycles, then rvalid gaps of 2 cycles -> AR fields stable
//     while waiting, addr_ok pulses once, line assembled correctly.
//  4. Error: rresp=2'b10 on beat 3 -> all 8 beats consumed,
//     mem_return_err=1 together with mem_return_en.
//  5. Short burst: rlast on beat 4 -> RESP after beat 4, words 5-7 = 0, err=1.
//  6. Back-to-back: request held high through RESP with addr 0x40 then 0x60 ->
//     second AR starts after one IDLE cycle, second line correct.

Source files
------------

// File: rtl/icache_refill_bridge.sv
// icache line-refill bridge: one request in, one AXI4 INCR burst out,
// beats packed into a full cache line returned with a single pulse.
module icache_refill_bridge #(
    parameter int              ADDR_W = 32,
    parameter int              LINE_W = 256,
    parameter int              AXI_DW = 32,
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache_mem_read_request,
    input  logic [ADDR_W-1:0] icache_mem_read_addr,
    output logic              mem_ready_to_read,
    output logic              mem_read_addr_ok,
    output logic              mem_return_en,
    output logic [LINE_W-1:0] mem_return_data,
    output logic              mem_return_err,
    output logic [ID_W-1:0]   arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [ID_W-1:0]   rid,
    input  logic [AXI_DW-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);

    localparam int BEATS = LINE_W / AXI_DW;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] OFS_MASK  = ADDR_W'(LINE_W / 8 - 1);
    localparam logic [2:0]        SIZE_ENC  = 3'($clog2(AXI_DW / 8));

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]            addr_q;
    logic [BEATS-1:0][AXI_DW-1:0] line_q;
    logic [CNT_W-1:0]             beat_q;
    logic                         err_q;
    logic                         first_q;
    logic                         idle_c, ar_c, r_c, resp_c;
    logic                         accept, beat_fire, beat_end, beat_bad;

    // rid is not checked: only one transaction is ever outstanding
    logic unused_rid;
    assign unused_rid = ^rid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        idle_c  = 1'b0;
        ar_c    = 1'b0;
        r_c     = 1'b0;
        resp_c  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                idle_c = 1'b1;
                if (icache_mem_read_request) state_d = S_AR;
            end
            S_AR: begin
                ar_c = 1'b1;
                if (arready) state_d = S_R;
            end
            S_R: begin
                r_c = 1'b1;
                if (rvalid && beat_end) state_d = S_RESP;
            end
            S_RESP: begin
                resp_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign accept    = idle_c && icache_mem_read_request;
    assign beat_fire = r_c && rvalid;
    assign beat_end  = rlast || (beat_q == LAST_BEAT);
    // early rlast or a missing rlast on the final beat both flag the line
    assign beat_bad  = (rresp != 2'b00) || (rlast != (beat_q == LAST_BEAT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            line_q  <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            first_q <= accept;
            if (accept) begin
                addr_q <= icache_mem_read_addr & ~OFS_MASK;
                line_q <= '0;
                beat_q <= '0;
                err_q  <= 1'b0;
            end else if (beat_fire) begin
                line_q[beat_q] <= rdata;
                beat_q         <= beat_q + 1'b1;
                if (beat_bad) err_q <= 1'b1;
            end
        end
    end

    assign mem_ready_to_read = idle_c;
    assign mem_read_addr_ok  = first_q;
    assign mem_return_en     = resp_c;
    assign mem_return_err    = resp_c && err_q;
    assign mem_return_data   = line_q;

    assign arvalid = ar_c;
    assign araddr  = addr_q;
    assign arid    = ar_c ? AXI_ID : '0;
    assign arlen   = ar_c ? 8'(BEATS - 1) : 8'd0;
    assign arsize  = ar_c ? SIZE_ENC : 3'd0;
    assign arburst = ar_c ? 2'b01 : 2'b00;
    assign rready  = r_c;

endmodule

// File: tb/tb_icache_refill_bridge.sv
// Directed bench for icache_refill_bridge: reset, refill, backpressure,
// error paths and back-to-back requests.
module tb_icache_refill_bridge;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         icache_mem_read_request;
    logic [31:0]  icache_mem_read_addr;
    logic         mem_ready_to_read;
    logic         mem_read_addr_ok;
    logic         mem_return_en;
    logic [255:0] mem_return_data;
    logic         mem_return_err;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    int tests = 0;
    int fails = 0;

    int           en_cyc;
    int           ok_cnt;
    int           ar_cyc;
    int           ar_bad;
    logic [255:0] got_data;
    logic         got_err;

    always #5 clk = ~clk;

    icache_refill_bridge dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .icache_mem_read_request (icache_mem_read_request),
        .icache_mem_read_addr    (icache_mem_read_addr),
        .mem_ready_to_read       (mem_ready_to_read),
        .mem_read_addr_ok        (mem_read_addr_ok),
        .mem_return_en           (mem_return_en),
        .mem_return_data         (mem_return_data),
        .mem_return_err          (mem_return_err),
        .arid                    (arid),
        .araddr                  (araddr),
        .arlen                   (arlen),
        .arsize                  (arsize),
        .arburst                 (arburst),
        .arvalid                 (arvalid),
        .arready                 (arready),
        .rid                     (rid),
        .rdata                   (rdata),
        .rresp                   (rresp),
        .rlast                   (rlast),
        .rvalid                  (rvalid),
        .rready                  (rready)
    );

    function automatic logic [255:0] mk_line(input logic [7:0] base, input int n);
        logic [255:0] l;
        l = '0;
        for (int i = 0; i < n; i++) l[32*i +: 32] = {24'h0, base} + 32'(i);
        return l;
    endfunction

    task automatic step_idle();
        @(posedge clk);
        #1;
    endtask

    // Cycle c = number of posedges since the request was raised.
    task automatic run_refill(input logic [31:0] a, input logic [7:0] base,
                              input int ar_wait, input int gap,
                              input int last_at, input int err_at,
                              input bit hold);
        int c, beat, g, arn;
        logic [31:0] exp_a;
        exp_a = a & ~32'h1F;
        c = 0; beat = 0; g = 0; arn = 0;
        en_cyc = -1; ok_cnt = 0; ar_cyc = 0; ar_bad = 0;
        got_data = '0; got_err = 1'b0;
        icache_mem_read_request = 1'b1;
        icache_mem_read_addr    = a;
        arready = 1'b0;
        while (en_cyc < 0 && c < 200) begin
            @(posedge clk);
            #1;
            c++;
            if (!hold) icache_mem_read_request = 1'b0;
            if (mem_read_addr_ok) ok_cnt++;
            if (mem_return_en) begin
                en_cyc   = c;
                got_data = mem_return_data;
                got_err  = mem_return_err;
            end
            if (arvalid) begin
                ar_cyc++;
                if (araddr !== exp_a || arlen !== 8'd7 || arsize !== 3'b010 ||
                    arburst !== 2'b01 || arid !== 4'd0) ar_bad++;
                arready = (arn >= ar_wait);
                arn++;
            end else begin
                arready = 1'b0;
            end
            if (rready && g == 0 && beat <= last_at && beat < 8) begin
                rvalid = 1'b1;
                rdata  = {24'h0, base} + 32'(beat);
                rresp  = (beat == err_at) ? 2'b10 : 2'b00;
                rlast  = (beat == last_at);
                rid    = 4'(beat);
                beat++;
                g = gap;
            end else begin
                rvalid = 1'b0;
                rlast  = 1'b0;
                rresp  = 2'b00;
                if (rready && g > 0) g--;
            end
        end
        rvalid  = 1'b0;
        arready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        tests++;
        if (mem_ready_to_read !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b want 1", mem_ready_to_read);
        end
        tests++;
        if ({mem_read_addr_ok, mem_return_en, mem_return_err, arvalid, rready} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {mem_read_addr_ok, mem_return_en, mem_return_err, arvalid, rready});
        end
        tests++;
        if (mem_return_data !== '0 || araddr !== '0 || arlen !== '0) begin
            fails++;
            $display("FAIL reset_data: got data %h addr %h len %h want 0",
                     mem_return_data, araddr, arlen);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step_idle();
    endtask

    task automatic test_basic();
        logic [255:0] exp;
        exp = mk_line(8'hA0, 8);
        run_refill(32'h1C00_0014, 8'hA0, 0, 0, 7, -1, 1'b0);
        tests++;
        if (en_cyc !== 10) begin
            fails++;
            $display("FAIL basic_latency: got %0d want 10", en_cyc);
        end
        tests++;
        if (ar_bad !== 0 || ar_cyc !== 1 || ok_cnt !== 1) begin
            fails++;
            $display("FAIL basic_ar: got bad=%0d ar=%0d ok=%0d want 0 1 1",
                     ar_bad, ar_cyc, ok_cnt);
        end
        tests++;
        if (got_data !== exp || got_err !== 1'b0) begin
            fails++;
            $display("FAIL basic_line: got %h err %b want %h err 0", got_data, got_err, exp);
        end
        step_idle();
        tests++;
        if (mem_return_en !== 1'b0 || mem_ready_to_read !== 1'b1 || mem_return_data !== exp) begin
            fails++;
            $display("FAIL basic_hold: got en %b rdy %b data %h want 0 1 %h",
                     mem_return_en, mem_ready_to_read, mem_return_data, exp);
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] exp;
        exp = mk_line(8'hB0, 8);
        run_refill(32'h0000_1234, 8'hB0, 3, 2, 7, -1, 1'b0);
        tests++;
        if (ar_cyc !== 4 || ar_bad !== 0 || ok_cnt !== 1) begin
            fails++;
            $display("FAIL bp_ar: got ar=%0d bad=%0d ok=%0d want 4 0 1", ar_cyc, ar_bad, ok_cnt);
        end
        tests++;
        if (en_cyc !== 27) begin
            fails++;
            $display("FAIL bp_latency: got %0d want 27", en_cyc);
        end
        tests++;
        if (got_data !== exp || got_err !== 1'b0) begin
            fails++;
            $display("FAIL bp_line: got %h err %b want %h err 0", got_data, got_err, exp);
        end
        step_idle();
    endtask

    task automatic test_error();
        logic [255:0] exp;
        exp = mk_line(8'hC0, 8);
        run_refill(32'h0000_2000, 8'hC0, 0, 0, 7, 3, 1'b0);
        tests++;
        if (en_cyc !== 10 || got_err !== 1'b1 || got_data !== exp) begin
            fails++;
            $display("FAIL err_resp: got cyc %0d err %b data %h want 10 1 %h",
                     en_cyc, got_err, got_data, exp);
        end
        step_idle();
    endtask

    task automatic test_short();
        logic [255:0] exp;
        exp = mk_line(8'hD0, 5);
        run_refill(32'h0000_3008, 8'hD0, 0, 0, 4, -1, 1'b0);
        tests++;
        if (en_cyc !== 7) begin
            fails++;
            $display("FAIL short_latency: got %0d want 7", en_cyc);
        end
        tests++;
        if (got_data !== exp || got_err !== 1'b1) begin
            fails++;
            $display("FAIL short_line: got %h err %b want %h err 1", got_data, got_err, exp);
        end
        step_idle();
    endtask

    task automatic test_no_rlast();
        logic [255:0] exp;
        exp = mk_line(8'hE0, 8);
        run_refill(32'h0000_4000, 8'hE0, 0, 0, 8, -1, 1'b0);
        tests++;
        if (en_cyc !== 10 || got_err !== 1'b1 || got_data !== exp) begin
            fails++;
            $display("FAIL no_rlast: got cyc %0d err %b data %h want 10 1 %h",
                     en_cyc, got_err, got_data, exp);
        end
        step_idle();
    endtask

    task automatic test_back_to_back();
        logic [255:0] exp1, exp2;
        exp1 = mk_line(8'h10, 8);
        exp2 = mk_line(8'h20, 8);
        run_refill(32'h0000_0040, 8'h10, 0, 0, 7, -1, 1'b1);
        tests++;
        if (en_cyc !== 10 || ok_cnt !== 1 || got_data !== exp1 || got_err !== 1'b0) begin
            fails++;
            $display("FAIL b2b_first: got cyc %0d ok %0d err %b data %h want 10 1 0 %h",
                     en_cyc, ok_cnt, got_err, got_data, exp1);
        end
        run_refill(32'h0000_0060, 8'h20, 0, 0, 7, -1, 1'b1);
        icache_mem_read_request = 1'b0;
        tests++;
        if (en_cyc !== 11 || ok_cnt !== 1 || ar_bad !== 0) begin
            fails++;
            $display("FAIL b2b_second_timing: got cyc %0d ok %0d bad %0d want 11 1 0",
                     en_cyc, ok_cnt, ar_bad);
        end
        tests++;
        if (got_data !== exp2 || got_err !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second_line: got %h err %b want %h err 0", got_data, got_err, exp2);
        end
        step_idle();
    endtask

    task automatic test_reset_mid_burst();
        int bad;
        icache_mem_read_request = 1'b1;
        icache_mem_read_addr    = 32'h0000_0080;
        arready = 1'b1;
        rvalid  = 1'b1;
        rdata   = 32'h55;
        rresp   = 2'b00;
        rlast   = 1'b0;
        step_idle();
        icache_mem_read_request = 1'b0;
        step_idle();
        step_idle();
        tests++;
        if (rready !== 1'b1) begin
            fails++;
            $display("FAIL midrst_in_r: got rready %b want 1", rready);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (mem_ready_to_read !== 1'b1 || rready !== 1'b0 || arvalid !== 1'b0 ||
            mem_return_en !== 1'b0 || mem_read_addr_ok !== 1'b0 || mem_return_data !== '0) begin
            fails++;
            $display("FAIL midrst_outputs: got rdy %b rr %b av %b en %b ok %b data %h want 1 0 0 0 0 0",
                     mem_ready_to_read, rready, arvalid, mem_return_en, mem_read_addr_ok,
                     mem_return_data);
        end
        rvalid  = 1'b0;
        arready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            step_idle();
            if (mem_return_en !== 1'b0 || mem_ready_to_read !== 1'b1) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL midrst_after: got %0d bad cycles want 0", bad);
        end
    endtask

    initial begin
        icache_mem_read_request = 1'b0;
        icache_mem_read_addr    = '0;
        arready = 1'b0;
        rid     = '0;
        rdata   = '0;
        rresp   = 2'b00;
        rlast   = 1'b0;
        rvalid  = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_error();
        test_short();
        test_no_rlast();
        test_back_to_back();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
